// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package product_acc_pkg;

    localparam int PROD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/product_acc_dp.sv
// Wrapping accumulator with sticky carry-out flag and frame product counter.
// Latency: state updates 1 cycle after add_en; sum_nxt/ovf_nxt/last are combinational.
// Backpressure: none; the controller gates add_en.
module product_acc_dp
    import product_acc_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum_nxt,
    output logic              ovf_nxt,
    output logic              last
);

    localparam int CNT_W = cnt_width(COUNT);
    localparam int SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_ext;

    // One extra bit captures the carry out of the accumulator width.
    assign sum_ext = SUM_W'(acc_q) + SUM_W'(prod);
    assign sum_nxt = sum_ext[ACC_W-1:0];
    assign ovf_nxt = ovf_q | sum_ext[ACC_W];
    assign last    = (cnt_q == CNT_W'(COUNT - 1));

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (add_en) begin
            acc_d = sum_nxt;
            ovf_d = ovf_nxt;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums a frame of COUNT products into a wrapping sum with sticky overflow.
// Latency: result valid 1 cycle after the last product is accepted.
// Backpressure: in_ready/out_valid come from registered state; HOLD waits on out_ready.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;

    logic             clr;
    logic             add_en;
    logic [ACC_W-1:0] sum_nxt;
    logic             ovf_nxt;
    logic             last;

    product_acc_dp #(
        .COUNT (COUNT),
        .ACC_W (ACC_W)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .add_en  (add_en),
        .prod    (in_prod),
        .sum_nxt (sum_nxt),
        .ovf_nxt (ovf_nxt),
        .last    (last)
    );

    always_comb begin
        state_d   = state_q;
        clr       = 1'b0;
        add_en    = 1'b0;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    clr     = 1'b1;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    add_en = 1'b1;
                    if (last) begin
                        state_d   = HOLD;
                        out_sum_d = sum_nxt;
                        out_ovf_d = ovf_nxt;
                    end
                end
            end
            HOLD: begin
                // A start coincident with the handshake reopens a frame with no idle bubble.
                if (out_ready) begin
                    if (start) begin
                        state_d = ACCUM;
                        clr     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench driving an 8-bit and a 5-bit accumulator in lockstep against a scoreboard.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [3:0] in_prod;
    logic       out_ready;

    logic       rdy8, bsy8, vld8, ovf8;
    logic [7:0] sum8;
    logic       rdy5, bsy5, vld5, ovf5;
    logic [4:0] sum5;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] s8;
        logic       o8;
        logic [4:0] s5;
        logic       o5;
    } exp_t;

    exp_t sb[$];

    int m_cnt;
    int m_acc8, m_acc5;
    logic m_ovf8, m_ovf5;

    always #5 clk = ~clk;

    product_accumulator #(.COUNT(4), .ACC_W(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (rdy8),
        .in_prod   (in_prod),
        .busy      (bsy8),
        .out_valid (vld8),
        .out_ready (out_ready),
        .out_sum   (sum8),
        .out_ovf   (ovf8)
    );

    product_accumulator #(.COUNT(4), .ACC_W(5)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (rdy5),
        .in_prod   (in_prod),
        .busy      (bsy5),
        .out_valid (vld5),
        .out_ready (out_ready),
        .out_sum   (sum5),
        .out_ovf   (ovf5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_acc8 = 0;
        m_acc5 = 0;
        m_ovf8 = 1'b0;
        m_ovf5 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready8"}, rdy8, 0);
        check({tag, "_in_ready5"}, rdy5, 0);
        check({tag, "_busy8"}, bsy8, 0);
        check({tag, "_out_valid8"}, vld8, 0);
        check({tag, "_out_valid5"}, vld5, 0);
        check({tag, "_out_sum8"}, sum8, 0);
        check({tag, "_out_sum5"}, sum5, 0);
        check({tag, "_out_ovf8"}, ovf8, 0);
        check({tag, "_out_ovf5"}, ovf5, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        model_clear();
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready8", rdy8, 1);
        check("start_in_ready5", rdy5, 1);
        check("start_busy8", bsy8, 1);
    endtask

    task automatic send_prod(input logic [3:0] p);
        exp_t e;
        in_valid = 1'b1;
        in_prod  = p;
        check("send_in_ready8", rdy8, 1);
        check("send_in_ready5", rdy5, 1);
        m_acc8 = m_acc8 + int'(p);
        if (m_acc8 > 255) begin
            m_ovf8 = 1'b1;
            m_acc8 = m_acc8 - 256;
        end
        m_acc5 = m_acc5 + int'(p);
        if (m_acc5 > 31) begin
            m_ovf5 = 1'b1;
            m_acc5 = m_acc5 - 32;
        end
        m_cnt++;
        if (m_cnt == 4) begin
            e.s8 = 8'(m_acc8);
            e.o8 = m_ovf8;
            e.s5 = 5'(m_acc5);
            e.o5 = m_ovf5;
            sb.push_back(e);
            m_cnt = 0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_prod  = 4'h0;
    endtask

    // Idle cycle inside a frame; junk data and an optional stray start must not disturb it.
    task automatic gap(input logic st);
        in_valid = 1'b0;
        in_prod  = 4'hf;
        start    = st;
        @(negedge clk);
        start    = 1'b0;
        in_prod  = 4'h0;
        check("gap_in_ready8", rdy8, 1);
        check("gap_out_valid8", vld8, 0);
    endtask

    task automatic get_result(input int stall, input logic nxt);
        exp_t       e;
        logic [7:0] s0;
        check("latency_out_valid8", vld8, 1);
        check("latency_out_valid5", vld5, 1);
        check("hold_in_ready8", rdy8, 0);
        s0 = sum8;
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("bp_out_valid8", vld8, 1);
            check("bp_out_sum8", sum8, s0);
        end
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_sum8", sum8, e.s8);
            check("out_ovf8", ovf8, e.o8);
            check("out_sum5", sum5, e.s5);
            check("out_ovf5", ovf5, e.o5);
        end
        out_ready = 1'b1;
        start     = nxt;
        if (nxt) model_clear();
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("post_hs_out_valid8", vld8, 0);
        if (nxt) begin
            check("b2b_in_ready8", rdy8, 1);
            check("b2b_in_ready5", rdy5, 1);
        end else begin
            check("post_hs_busy8", bsy8, 0);
            check("post_hs_busy5", bsy5, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = 4'h0;
        out_ready = 1'b0;
        model_clear();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Released from reset with in_valid high but no start: must stay idle.
        rst      = 1'b0;
        in_valid = 1'b1;
        in_prod  = 4'h7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_reset_outputs("idle");
        end
        in_valid = 1'b0;
        in_prod  = 4'h0;

        // Basic frame: 9+6+4+1 = 20.
        do_start();
        send_prod(4'd9);
        send_prod(4'd6);
        send_prod(4'd4);
        send_prod(4'd1);
        get_result(0, 1'b0);

        // Overflow frame: 36 -> 8-bit 36, 5-bit 4 with carry.
        do_start();
        for (int i = 0; i < 4; i++) send_prod(4'd9);
        get_result(0, 1'b0);

        // Stalled input pattern 1,0,0,1,0,1,1 then 5 cycles of back-pressure; next frame starts at handshake.
        do_start();
        send_prod(4'd2);
        gap(1'b0);
        gap(1'b0);
        send_prod(4'd3);
        gap(1'b0);
        send_prod(4'd1);
        send_prod(4'd3);
        get_result(5, 1'b1);

        // Back-to-back frame with a stray start mid-frame: 1+1+1+1 = 4.
        send_prod(4'd1);
        gap(1'b1);
        send_prod(4'd1);
        send_prod(4'd1);
        send_prod(4'd1);
        get_result(0, 1'b0);

        // Reset after 2 of 4 products discards the frame.
        do_start();
        send_prod(4'd4);
        send_prod(4'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_reset_outputs("midrst");

        do_start();
        for (int i = 0; i < 4; i++) send_prod(4'd4);
        get_result(2, 1'b0);

        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential consumer stage directly downstream of the 2x2 array multiplier. Accepts a frame of COUNT 4-bit products over a valid/ready handshake, sums them into a wrapping accumulator with a sticky overflow flag, and presents the frame sum on a second valid/ready handshake. It turns the combinational multiplier into a dot-product building block.

## Interface
- COUNT, 4, number of products per frame; legal range 1..255
- ACC_W, 8, accumulator and result width in bits; must be at least 4
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to open a new frame
- in_valid  input  1  in_prod is valid this cycle
- in_ready  output  1  block accepts a product this cycle
- in_prod  input  4  unsigned product from the multiplier
- busy  output  1  high while a frame is open or a result is held (state != IDLE)
- out_valid  output  1  out_sum and out_ovf are valid
- out_ready  input  1  downstream accepts the result
- out_sum  output  ACC_W  frame sum modulo 2^ACC_W
- out_ovf  output  1  at least one accumulation in the frame carried out of ACC_W bits

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE: in_ready=0, out_valid=0. If start=1, go to ACCUM with acc=0, cnt=0, ovf=0.
- ACCUM: in_ready=1. A product is accepted when in_valid && in_ready. On acceptance, acc <= acc + zero-extended in_prod, truncated to ACC_W bits; ovf <= ovf | carry-out; cnt <= cnt+1.
- On acceptance with cnt == COUNT-1, go to HOLD. out_sum and out_ovf are loaded with the final acc and ovf values, including this product.
- HOLD: in_ready=0, out_valid=1. out_sum and out_ovf stay stable until out_valid && out_ready, then go to IDLE.
- If HOLD handshakes and start=1 in the same cycle, go straight to ACCUM with acc, cnt and ovf cleared. No IDLE bubble.
- start is ignored in ACCUM, and in HOLD without a handshake.
- in_valid is ignored outside ACCUM. Products are never dropped silently: they are accepted only when in_ready=1.
- Unsigned arithmetic throughout. cnt width is clog2(COUNT+1).

## Timing
- Reset values: state=IDLE, in_ready=0, busy=0, out_valid=0, out_sum=0, out_ovf=0. Internal acc=0, cnt=0.
- rst has priority over every other input. Asserting rst in ACCUM or HOLD discards the frame and the pending result. The cycle after rst deasserts, the block is in IDLE.
- in_ready and busy are decoded from the registered state only. There is no combinational path from in_valid or out_ready.
- Minimum frame: start at cycle 0. In_ready is high from cycle 1. With one product per cycle, the last product is accepted at cycle COUNT and out_valid is high from cycle COUNT+1.
- Result latency: out_valid asserts exactly 1 cycle after the final product is accepted.
- Gaps in in_valid stall the count without side effects. Back-pressure on out_ready holds HOLD indefinitely.
- Throughput with back-to-back frames is COUNT+1 cycles per frame, using start coincident with the result handshake.

## Structure
- Shared package product_acc_pkg holds:
  - the state typedef: IDLE, ACCUM, HOLD;
  - PROD_W = 4;
  - the helper function for cnt width.
- One natural sub-module, product_acc_dp, contains the accumulator register, carry/ovf logic and frame counter. It has clear, add-enable and last-flag ports. The top level holds the FSM and handshake decode.
- The multiplier itself is not instantiated here. The integration level wires its output to in_prod.

## Test plan
- Reset and idle: hold rst 3 cycles, then drive in_valid=1 with no start.
  - Required: in_ready=0, busy=0, out_valid=0, out_sum=0, out_ovf=0 throughout.
- Basic frame, default parameters: start, then products 9, 6, 4, 1 on consecutive cycles.
  - Required: out_valid rises 1 cycle after the 4th accept, out_sum=20, out_ovf=0.
- Overflow with ACC_W=5, COUNT=4: products 9, 9, 9, 9.
  - Required: out_sum=4 (36 mod 32), out_ovf=1.
- Stalls and back-pressure:
  - in_valid toggles 1,0,0,1,0,1,1 carrying 2, 3, 1, 3. Required: out_sum=9.
  - Hold out_ready=0 for 5 cycles. Required: out_valid and out_sum stay stable; the handshake happens on the first out_ready=1 cycle.
- Back-to-back frames: assert start in the same cycle as the HOLD handshake, then send 1, 1, 1, 1.
  - Required: in_ready=1 the next cycle, second out_sum=4.
  - Required: start pulses during ACCUM are ignored.
- Reset mid-frame: assert rst after 2 of 4 products.
  - Required: IDLE next cycle, all outputs at reset values.
  - A new frame of 4, 4, 4, 4 then gives out_sum=16.
